regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single RegisterFile write port (wen/rd/din) between two writeback
//  requesters: port 0 = ALU, port 1 = load unit. Uses valid/ready handshakes and
//  round-robin arbitration on conflict. Drives a registered write to the regfile.
//  Keeps a pending-write scoreboard so issue logic can detect RAW hazards on rs1/rs2.
// PARAMETERS
//  DATA_W  32  width of writeback data / regfile din
//  ADDR_W   5  register index width; NREG = 2**ADDR_W entries in the scoreboard
// PORTS
//  clk         in   1       single clock, rising edge
//  rst         in   1       synchronous, active-high reset
//  wb0_valid   in   1       ALU writeback request
//  wb0_rd      in   ADDR_W  ALU destination register
//  wb0_data    in   DATA_W  ALU result
//  wb0_ready   out  1       ALU request accepted this cycle
//  wb1_valid   in   1       load-unit writeback request
//  wb1_rd      in   ADDR_W  load destination register
//  wb1_data    in   DATA_W  load data
//  wb1_ready   out  1       load request accepted this cycle
//  rf_wen      out  1       to RegisterFile wen
//  rf_rd       out  ADDR_W  to RegisterFile rd
//  rf_din      out  DATA_W  to RegisterFile din
//  iss_valid   in   1       issue stage reserves a destination register
//  iss_rd      in   ADDR_W  register being reserved
//  chk_rs1     in   ADDR_W  source 1 to hazard-check
//  chk_rs2     in   ADDR_W  source 2 to hazard-check
//  haz_rs1     out  1       pend[chk_rs1] (combinational)
//  haz_rs2     out  1       pend[chk_rs2] (combinational)
//  pend        out  NREG    full scoreboard vector
// BEHAVIOUR
//  - Reset: rf_wen=0, rf_rd=0, rf_din=0, pend=0, last_grant=1 (port 0 wins first conflict).
//  - Handshake: wbN_ready is combinational, high only in the cycle port N is granted.
//    A requester holds valid/rd/data stable until ready. Transfer = valid&ready.
//  - Arbitration: one valid -> grant it. Both valid -> grant port != last_grant.
//    last_grant updates on every transfer. Neither valid -> no grant, no ready.
//  - Latency: on a transfer at edge T, rf_wen/rf_rd/rf_din load at T. RegisterFile
//    writes at edge T+1. No transfer -> rf_wen=0 next cycle; rf_rd/rf_din hold.
//  - x0: a transfer with rd==0 is accepted (ready=1) but loads rf_wen=0.
//  - Throughput: one transfer per cycle; the losing port waits at most 1 cycle.
//  - Scoreboard set: iss_valid & iss_rd!=0 sets pend[iss_rd] at the next edge.
//  - Scoreboard clear: rf_wen=1 clears pend[rf_rd] at the same edge the regfile writes.
//  - Same-edge set and clear on one index: set wins, because a new producer is outstanding.
//  - pend[0] is always 0. haz_rs1/haz_rs2 are pure lookups and add no extra bypass.
//  - Writes without a prior reservation are legal and leave pend unchanged.
//  - Reset mid-operation: any in-flight rf_wen is dropped (0 next cycle), pend clears,
//    and no ready is asserted in a cycle where rst=1.
// TESTING
//  1 Reset: rst=1 for 2 cycles with wb0_valid=1 -> wb0_ready=0, rf_wen=0, pend=0.
//  2 Single write: wb0 {rd=10, data=BABEFACE} -> ready same cycle, rf_wen=1, rf_rd=10,
//    rf_din=BABEFACE next cycle, and regfile r1 at rs1=10 reads BABEFACE afterward.
//  3 Conflict: both valid for 3 cycles (rd=2/rd=3) -> grants 0,1,0, and rf_rd is 2,3,2.
//  4 x0: wb1 {rd=0, data=FFFFFFFF} -> wb1_ready=1, rf_wen stays 0, and x0 still reads 0.
//  5 Scoreboard: iss rd=5 -> pend[5]=1 and haz_rs1=1 at chk_rs1=5. When the wb write to 5
//    commits -> pend[5]=0. Reserve rd=5 on the same commit edge -> pend[5] stays 1.
//  6 Mid-op reset: assert rst while rf_wen=1 and pend!=0 -> next cycle rf_wen=0, pend=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single RegisterFile write port (port 0 = ALU, port 1 = load unit),
// plus a pending-write scoreboard used by issue logic for RAW hazard detection.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   localparam int NREG  = 2 ** ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb0_valid,
   input  logic [ADDR_W-1:0] wb0_rd,
   input  logic [DATA_W-1:0] wb0_data,
   output logic              wb0_ready,
   input  logic              wb1_valid,
   input  logic [ADDR_W-1:0] wb1_rd,
   input  logic [DATA_W-1:0] wb1_data,
   output logic              wb1_ready,
   output logic              rf_wen,
   output logic [ADDR_W-1:0] rf_rd,
   output logic [DATA_W-1:0] rf_din,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_rd,
   input  logic [ADDR_W-1:0] chk_rs1,
   input  logic [ADDR_W-1:0] chk_rs2,
   output logic              haz_rs1,
   output logic              haz_rs2,
   output logic [NREG-1:0]   pend
);

   logic              grant0_s;
   logic              grant1_s;
   logic              xfer_s;
   logic [ADDR_W-1:0] sel_rd_s;
   logic [DATA_W-1:0] sel_data_s;
   logic [NREG-1:0]   pend_nxt_s;

   logic              last_grant_r;
   logic              rf_wen_r;
   logic [ADDR_W-1:0] rf_rd_r;
   logic [DATA_W-1:0] rf_din_r;
   logic [NREG-1:0]   pend_r;

   // Round-robin grant; no grant at all while reset is asserted
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (rst) begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end else if (wb0_valid && wb1_valid) begin
         if (last_grant_r) begin
            grant0_s = 1'b1;
         end else begin
            grant1_s = 1'b1;
         end
      end else if (wb0_valid) begin
         grant0_s = 1'b1;
      end else if (wb1_valid) begin
         grant1_s = 1'b1;
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   // Select the granted requester's destination and data
   always_comb begin
      sel_rd_s   = {ADDR_W{1'b0}};
      sel_data_s = {DATA_W{1'b0}};
      if (grant1_s) begin
         sel_rd_s   = wb1_rd;
         sel_data_s = wb1_data;
      end else begin
         sel_rd_s   = wb0_rd;
         sel_data_s = wb0_data;
      end
   end

   assign xfer_s = grant0_s | grant1_s;

   // Scoreboard next state: clear on commit, then set on reservation so a new producer wins
   always_comb begin
      pend_nxt_s = pend_r;
      if (rf_wen_r) begin
         pend_nxt_s[rf_rd_r] = 1'b0;
      end else begin
         pend_nxt_s = pend_r;
      end
      if (iss_valid && (iss_rd != {ADDR_W{1'b0}})) begin
         pend_nxt_s[iss_rd] = 1'b1;
      end else begin
         pend_nxt_s[0] = 1'b0;
      end
      pend_nxt_s[0] = 1'b0;
   end

   // Registered write port, arbitration history and scoreboard
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_r <= 1'b1;
         rf_wen_r     <= 1'b0;
         rf_rd_r      <= {ADDR_W{1'b0}};
         rf_din_r     <= {DATA_W{1'b0}};
         pend_r       <= {NREG{1'b0}};
      end else begin
         pend_r <= pend_nxt_s;
         if (xfer_s) begin
            last_grant_r <= grant1_s;
            // x0 is accepted but never written
            rf_wen_r     <= (sel_rd_s != {ADDR_W{1'b0}});
            rf_rd_r      <= sel_rd_s;
            rf_din_r     <= sel_data_s;
         end else begin
            rf_wen_r     <= 1'b0;
         end
      end
   end

   assign wb0_ready = grant0_s;
   assign wb1_ready = grant1_s;
   assign rf_wen    = rf_wen_r;
   assign rf_rd     = rf_rd_r;
   assign rf_din    = rf_din_r;
   assign pend      = pend_r;
   assign haz_rs1   = pend_r[chk_rs1];
   assign haz_rs2   = pend_r[chk_rs2];

endmodule
